// File: rtl/trig_cnt_readout_ctrl.sv
// trig_cnt_readout_ctrl
// Snapshots the five 32-bit trigger counters into shadow registers and streams
// them as a 6-word frame (header + L1A, PL1A, PS, ALIGN, DELTA) over a
// valid/ready port. Owns the counter block reset, so it also sequences clears
// (on request, or atomically with each snapshot when clr_on_read is set) and
// runs a periodic auto-snapshot timer.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cnt_*           live counter values from the trigger counter block
//   snap_req        snapshot request pulse
//   clr_req         counter clear request pulse
//   clr_on_read     clear counters on the capture edge of every snapshot
//   auto_period     cycles between auto snapshots, 0 disables
//   cnt_rst         reset to the trigger counter block
//   rd_data/rd_valid/rd_ready/rd_last   frame output stream
//   busy            controller not idle
//   snap_seq        frames sent (wraps)
//   snap_drop       requests lost while a request was already pending (saturates)
module trig_cnt_readout_ctrl #(
    parameter logic [7:0]  HDR_TAG = 8'hC5,
    parameter int unsigned AUTO_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cnt_L1A,
    input  logic [31:0]       cnt_PL1A,
    input  logic [31:0]       cnt_PS,
    input  logic [31:0]       cnt_ALIGN,
    input  logic [31:0]       cnt_DELTA,
    input  logic              snap_req,
    input  logic              clr_req,
    input  logic              clr_on_read,
    input  logic [AUTO_W-1:0] auto_period,
    output logic              cnt_rst,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              busy,
    output logic [15:0]       snap_seq,
    output logic [7:0]        snap_drop
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEQ_W  = 16;
    localparam int unsigned DROP_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned N_CNT  = 5;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_CNT);
    localparam logic [7:0]       HDR_NWORDS = 8'(N_CNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_SEND,
        ST_CLR
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   shadow_q [N_CNT];
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                rd_last_q;
    logic                cnt_rst_q;
    logic [SEQ_W-1:0]    snap_seq_q;
    logic [DROP_W-1:0]   snap_drop_q;
    logic                snap_pend_q;
    logic                clr_pend_q;
    logic [AUTO_W-1:0]   timer_q;

    logic                auto_en_c;
    logic                tick_c;
    logic                snap_ev_c;
    logic                accept_c;
    logic [DATA_W-1:0]   next_word_c;

    // Auto timer compare; >= keeps the timer bounded if the period shrinks mid-count
    always_comb begin
        auto_en_c = (auto_period != '0);
        tick_c    = auto_en_c && (timer_q >= (auto_period - AUTO_W'(1)));
        snap_ev_c = snap_req | tick_c;
        accept_c  = rd_valid_q & rd_ready;
    end

    // Count word following the current index (word k carries shadow k-1)
    always_comb begin
        next_word_c = shadow_q[0];
        case (idx_q)
            3'd0:    next_word_c = shadow_q[0];
            3'd1:    next_word_c = shadow_q[1];
            3'd2:    next_word_c = shadow_q[2];
            3'd3:    next_word_c = shadow_q[3];
            3'd4:    next_word_c = shadow_q[4];
            default: next_word_c = shadow_q[0];
        endcase
    end

    // Controller FSM, request bookkeeping, timer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            cnt_rst_q   <= 1'b1;
            snap_seq_q  <= '0;
            snap_drop_q <= '0;
            snap_pend_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            timer_q     <= '0;
            for (int i = 0; i < int'(N_CNT); i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            if (!auto_en_c || tick_c) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + AUTO_W'(1);
            end

            cnt_rst_q <= 1'b0;

            // Requests arriving while busy: 1-deep snapshot queue, sticky clear
            if (state_q != ST_IDLE) begin
                if (snap_ev_c) begin
                    if (snap_pend_q) begin
                        if (snap_drop_q != '1) begin
                            snap_drop_q <= snap_drop_q + DROP_W'(1);
                        end
                    end else begin
                        snap_pend_q <= 1'b1;
                    end
                end
                if (clr_req) begin
                    clr_pend_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (snap_ev_c || snap_pend_q) begin
                        state_q     <= ST_ARM;
                        cnt_rst_q   <= clr_on_read;
                        // A fresh request on the cycle a pending one is served stays queued
                        snap_pend_q <= snap_pend_q && snap_ev_c;
                        if (clr_req) begin
                            clr_pend_q <= 1'b1;
                        end
                    end else if (clr_req || clr_pend_q) begin
                        state_q    <= ST_CLR;
                        cnt_rst_q  <= 1'b1;
                        clr_pend_q <= 1'b0;
                    end
                end
                ST_ARM: begin
                    // Capture edge; with clr_on_read the counters reset on this same edge
                    shadow_q[0] <= cnt_L1A;
                    shadow_q[1] <= cnt_PL1A;
                    shadow_q[2] <= cnt_PS;
                    shadow_q[3] <= cnt_ALIGN;
                    shadow_q[4] <= cnt_DELTA;
                    state_q     <= ST_SEND;
                    idx_q       <= '0;
                    rd_valid_q  <= 1'b1;
                    rd_last_q   <= 1'b0;
                    rd_data_q   <= {HDR_TAG, HDR_NWORDS, snap_seq_q};
                end
                ST_SEND: begin
                    if (accept_c) begin
                        if (idx_q == LAST_IDX) begin
                            state_q    <= ST_IDLE;
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                            snap_seq_q <= snap_seq_q + SEQ_W'(1);
                        end else begin
                            idx_q     <= idx_q + IDX_W'(1);
                            rd_data_q <= next_word_c;
                            rd_last_q <= (idx_q == (LAST_IDX - IDX_W'(1)));
                        end
                    end
                end
                ST_CLR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cnt_rst   = cnt_rst_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign snap_seq  = snap_seq_q;
    assign snap_drop = snap_drop_q;

endmodule
